// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready on the input and on each output channel.
// Define DEMUX_CNT_EN to add the 16-bit accepted-beat counter output cnt_total.
module demux_1to4_reg #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]        cnt_total
`endif
);

    logic [3:0]       valid_reg;
    logic [3:0]       valid_next;
    logic [WIDTH-1:0] data_reg  [4];
    logic [WIDTH-1:0] data_next [4];
    logic [3:0]       load;
    logic             in_fire;

    // Only the addressed channel can stall the input; a draining channel can be refilled
    // in the same cycle, which is what allows one beat per cycle on a single channel.
    assign in_ready = !rst && (!valid_reg[in_sel] || out_ready[in_sel]);
    assign in_fire  = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            assign load[gi]       = in_fire && (in_sel == 2'(gi));
            // A load wins over a drain; otherwise the beat stays until its sink takes it.
            assign valid_next[gi] = load[gi] || (valid_reg[gi] && !out_ready[gi]);
            assign data_next[gi]  = load[gi] ? in_data : data_reg[gi];
            assign out_data[gi*WIDTH +: WIDTH] = data_reg[gi];
        end
    endgenerate

    assign out_valid = valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_reg[k] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            for (int k = 0; k < 4; k++) begin
                data_reg[k] <= data_next[k];
            end
        end
    end

`ifdef DEMUX_CNT_EN
    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;

    // Counts accepted input beats only; wraps naturally at 16 bits.
    assign cnt_next  = in_fire ? cnt_reg + 16'd1 : cnt_reg;
    assign cnt_total = cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 16'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Self-checking bench for demux_1to4_reg: directed vector table, queue-based reference model
// with randomized traffic, and (with DEMUX_CNT_EN) the 70000-beat counter wrap test.
`timescale 1ns/1ps
module tb_demux_1to4_reg;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic [1:0]     in_sel = 2'd0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready = 4'b0000;
`ifdef DEMUX_CNT_EN
    logic [15:0]    cnt_total;
`endif

    demux_1to4_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt_total (cnt_total)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: each channel is a FIFO of beats waiting for its sink (at most one
    // entry by construction), plus the last payload written so the held data can be checked.
    typedef logic [W-1:0] beat_q_t[$];
    beat_q_t      mq [4];
    logic [W-1:0] last_data [4];
    int unsigned  mcnt = 0;
    int unsigned  accepted = 0;
    logic         stalled = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic model_ready();
        return !rst && (mq[in_sel].size() == 0 || out_ready[in_sel]);
    endfunction

    task automatic check_all(input string tag);
        logic [3:0]     eov;
        logic [4*W-1:0] eod;
        for (int k = 0; k < 4; k++) begin
            eov[k] = (mq[k].size() != 0);
            eod[k*W +: W] = eov[k] ? mq[k][0] : last_data[k];
        end
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(model_ready()));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(eov));
        chk({tag, ".out_data"}, 64'(out_data), 64'(eod));
`ifdef DEMUX_CNT_EN
        chk({tag, ".cnt_total"}, 64'(cnt_total), 64'(mcnt % 65536));
`endif
    endtask

    // Applied at each rising edge using the inputs that were held through the cycle.
    task automatic model_update();
        logic rdy;
        rdy = model_ready();
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                last_data[k] = '0;
            end
            mcnt    = 0;
            stalled = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
            end
            if (in_valid && rdy) begin
                mq[in_sel].push_back(in_data);
                last_data[in_sel] = in_data;
                mcnt++;
                accepted++;
            end
            stalled = in_valid && !rdy;
        end
    endtask

    task automatic tick(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic           rst;
        logic           vld;
        logic [1:0]     sel;
        logic [W-1:0]   data;
        logic [3:0]     ordy;
        logic           exp_rdy;
        logic [3:0]     exp_ov;
        logic [4*W-1:0] exp_od;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] o, input logic er, input logic [3:0] eov,
                       input logic [4*W-1:0] eod);
        vec_t t;
        t.rst = r; t.vld = v; t.sel = s; t.data = d; t.ordy = o;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod;
        vecs.push_back(t);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) last_data[k] = '0;

        // Reset held with a live beat presented; nothing may be captured.
        add(1, 1, 2'd2, 8'hAA, 4'b0000, 0, 4'b0000, 32'h00000000);
        add(0, 0, 2'd2, 8'hAA, 4'b0000, 1, 4'b0000, 32'h00000000);
        add(0, 0, 2'd2, 8'hAA, 4'b1111, 1, 4'b0000, 32'h00000000);
        // One beat per channel, one cycle latency.
        add(0, 1, 2'd0, 8'h11, 4'b1111, 1, 4'b0000, 32'h00000000);
        add(0, 1, 2'd1, 8'h22, 4'b1111, 1, 4'b0001, 32'h00000011);
        add(0, 1, 2'd2, 8'h33, 4'b1111, 1, 4'b0010, 32'h00002211);
        add(0, 1, 2'd3, 8'h44, 4'b1111, 1, 4'b0100, 32'h00332211);
        add(0, 0, 2'd0, 8'h00, 4'b1111, 1, 4'b1000, 32'h44332211);
        // Backpressure on ch0 must not block ch1.
        add(0, 1, 2'd0, 8'h5A, 4'b1110, 1, 4'b0000, 32'h44332211);
        add(0, 1, 2'd0, 8'h5B, 4'b1110, 0, 4'b0001, 32'h4433225A);
        add(0, 1, 2'd0, 8'h5B, 4'b1110, 0, 4'b0001, 32'h4433225A);
        add(0, 1, 2'd1, 8'h5C, 4'b1110, 1, 4'b0001, 32'h4433225A);
        add(0, 1, 2'd0, 8'h5B, 4'b1111, 1, 4'b0011, 32'h44335C5A);
        add(0, 0, 2'd0, 8'h00, 4'b1111, 1, 4'b0001, 32'h44335C5B);
        add(0, 0, 2'd0, 8'h00, 4'b1111, 1, 4'b0000, 32'h44335C5B);
        // Fill ch2, then drain and reload it every cycle for 8 beats.
        add(0, 1, 2'd2, 8'h01, 4'b0000, 1, 4'b0000, 32'h44335C5B);
        for (int i = 0; i < 8; i++)
            add(0, 1, 2'd2, 8'(8'h02 + i), 4'b0100, 1, 4'b0100,
                {8'h44, 8'(8'h01 + i), 8'h5C, 8'h5B});
        add(0, 0, 2'd2, 8'h00, 4'b0100, 1, 4'b0100, 32'h44095C5B);
        add(0, 0, 2'd2, 8'h00, 4'b0000, 1, 4'b0000, 32'h44095C5B);
        // Reset while ch0 and ch3 are full and stalled.
        add(0, 1, 2'd0, 8'hA0, 4'b0000, 1, 4'b0000, 32'h44095C5B);
        add(0, 1, 2'd3, 8'hA3, 4'b0000, 1, 4'b0001, 32'h44095CA0);
        add(1, 0, 2'd0, 8'h00, 4'b0000, 0, 4'b1001, 32'hA3095CA0);
        add(0, 0, 2'd0, 8'h00, 4'b1111, 1, 4'b0000, 32'h00000000);
        add(0, 0, 2'd0, 8'h00, 4'b1111, 1, 4'b0000, 32'h00000000);

        // First reset cycle; outputs are undefined until this edge.
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hAA;
        @(negedge clk);
        chk("pre_reset.in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        model_update();
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            rst = vecs[i].rst; in_valid = vecs[i].vld; in_sel = vecs[i].sel;
            in_data = vecs[i].data; out_ready = vecs[i].ordy;
            @(negedge clk);
            chk({tag, ".tbl_in_ready"}, 64'(in_ready), 64'(vecs[i].exp_rdy));
            chk({tag, ".tbl_out_valid"}, 64'(out_valid), 64'(vecs[i].exp_ov));
            chk({tag, ".tbl_out_data"}, 64'(out_data), 64'(vecs[i].exp_od));
            check_all(tag);
            @(posedge clk);
            model_update();
            #1;
        end

        // Random traffic; a stalled beat is held stable until it is taken.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom);
            end
            out_ready = 4'($urandom);
            tick($sformatf("rnd%0d", i));
        end

`ifdef DEMUX_CNT_EN
        rst = 1'b1; in_valid = 1'b0;
        tick("cnt_reset");
        rst = 1'b0;
        accepted = 0;
        out_ready = 4'b1111;
        while (accepted < 70000) begin
            in_valid = ($urandom_range(0, 15) != 0);
            in_sel   = 2'($urandom_range(0, 3));
            in_data  = 8'($urandom);
            tick("cnt_run");
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_wrap", 64'(cnt_total), 64'(16'd4464));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
